// File: rtl/divisor_algoritmico.sv
// Signed restoring divider: one quotient bit per clock, truncating (C-style) results.
// Start in IDLE captures operand magnitudes and signs; Done pulses once when Coc/Res are updated.
module divisor_algoritmico #(
  parameter int tamanyo = 32
) (
  input  logic               CLK,
  input  logic               RSTn,
  input  logic               Start,
  input  logic [tamanyo-1:0] Num,
  input  logic [tamanyo-1:0] Den,
  output logic [tamanyo-1:0] Coc,
  output logic [tamanyo-1:0] Res,
  output logic               Done
);

  localparam int W  = tamanyo;
  localparam int CW = $clog2(W + 1);

  typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

  state_t          state_q, state_d;
  logic [W:0]      rem_q, rem_d;
  logic [W-1:0]    quo_q, quo_d;
  logic [W-1:0]    den_q, den_d;
  logic [W-1:0]    num_q, num_d;
  logic            sgnq_q, sgnq_d;
  logic            sgnr_q, sgnr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [W-1:0]    coc_q, coc_d;
  logic [W-1:0]    res_q, res_d;
  logic            done_q, done_d;

  // Magnitudes as unsigned: the most-negative value maps to 2^(W-1).
  logic [W-1:0] num_abs, den_abs;
  assign num_abs = Num[W-1] ? -Num : Num;
  assign den_abs = Den[W-1] ? -Den : Den;

  logic [W:0] shifted, trial;
  assign shifted = {rem_q[W-1:0], quo_q[W-1]};
  assign trial   = shifted - {1'b0, den_q};

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q <= IDLE;
      rem_q   <= '0;
      quo_q   <= '0;
      den_q   <= '0;
      num_q   <= '0;
      sgnq_q  <= 1'b0;
      sgnr_q  <= 1'b0;
      cnt_q   <= '0;
      coc_q   <= '0;
      res_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      den_q   <= den_d;
      num_q   <= num_d;
      sgnq_q  <= sgnq_d;
      sgnr_q  <= sgnr_d;
      cnt_q   <= cnt_d;
      coc_q   <= coc_d;
      res_q   <= res_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    den_d   = den_q;
    num_d   = num_q;
    sgnq_d  = sgnq_q;
    sgnr_d  = sgnr_q;
    cnt_d   = cnt_q;
    coc_d   = coc_q;
    res_d   = res_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (Start) begin
          rem_d   = '0;
          quo_d   = num_abs;
          den_d   = den_abs;
          num_d   = Num;
          sgnq_d  = Num[W-1] ^ Den[W-1];
          sgnr_d  = Num[W-1];
          cnt_d   = CW'(W);
          state_d = CALC;
        end
      end
      CALC: begin
        // Keep the trial difference only when it did not go negative.
        if (!trial[W]) begin
          rem_d = trial;
          quo_d = {quo_q[W-2:0], 1'b1};
        end else begin
          rem_d = shifted;
          quo_d = {quo_q[W-2:0], 1'b0};
        end
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = FIN;
      end
      FIN: begin
        if (den_q == '0) begin
          coc_d = '1;
          res_d = num_q;
        end else begin
          coc_d = sgnq_q ? -quo_q : quo_q;
          res_d = sgnr_q ? -rem_q[W-1:0] : rem_q[W-1:0];
        end
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign Coc  = coc_q;
  assign Res  = res_q;
  assign Done = done_q;

endmodule

// File: tb/tb_divisor_algoritmico.sv
// Directed bench for divisor_algoritmico (tamanyo=32): results, Done latency, reset and Start handling.
module tb_divisor_algoritmico;

  logic        CLK = 1'b0;
  logic        RSTn = 1'b0;
  logic        Start = 1'b0;
  logic [31:0] Num = '0;
  logic [31:0] Den = '0;
  logic [31:0] Coc, Res;
  logic        Done;

  int passed = 0;
  int total  = 0;

  divisor_algoritmico #(.tamanyo(32)) dut (
    .CLK(CLK), .RSTn(RSTn), .Start(Start), .Num(Num), .Den(Den),
    .Coc(Coc), .Res(Res), .Done(Done)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Launch one division; optionally re-pulse Start during CALC at edge glitch_at.
  task automatic run_div(input string tag, input logic [31:0] n, input logic [31:0] d,
                         input logic [31:0] exp_c, input logic [31:0] exp_r, input int glitch_at);
    int edges;
    @(negedge CLK);
    Num = n; Den = d; Start = 1'b1;
    @(posedge CLK); #1;
    Start = 1'b0;
    Num = 32'h5A5A_5A5A; Den = 32'h0000_0003;
    edges = 0;
    while (edges < 100) begin
      @(posedge CLK); #1;
      edges++;
      Start = (edges == glitch_at);
      if (Done) break;
    end
    Start = 1'b0;
    chk({tag, "_lat"}, 32'(edges), 32'd33);
    chk({tag, "_coc"}, Coc, exp_c);
    chk({tag, "_res"}, Res, exp_r);
    $display("div %s: Num=%0d Den=%0d -> Coc=%0d Res=%0d after %0d edges",
             tag, $signed(n), $signed(d), $signed(Coc), $signed(Res), edges);
    @(posedge CLK); #1;
    chk({tag, "_done_low"}, 32'(Done), 32'd0);
  endtask

  initial begin
    int dcount;
    #12;
    chk("rst_coc", Coc, 32'd0);
    chk("rst_res", Res, 32'd0);
    chk("rst_done", 32'(Done), 32'd0);
    @(negedge CLK); RSTn = 1'b1;

    run_div("m2_2", -32'sd2, 32'sd2, -32'sd1, 32'd0, 0);
    repeat (2) @(posedge CLK);
    run_div("2_2", 32'd2, 32'd2, 32'd1, 32'd0, 0);
    repeat (5) @(posedge CLK);
    #1;
    chk("hold_coc", Coc, 32'd1);
    chk("hold_res", Res, 32'd0);

    run_div("7_2",   32'sd7,  32'sd2,  32'sd3,  32'sd1, 0);
    run_div("m7_2",  -32'sd7, 32'sd2,  -32'sd3, -32'sd1, 0);
    run_div("7_m2",  32'sd7,  -32'sd2, -32'sd3, 32'sd1, 0);
    run_div("m7_m2", -32'sd7, -32'sd2, 32'sd3,  -32'sd1, 0);
    run_div("0_5",   32'sd0,  32'sd5,  32'sd0,  32'sd0, 0);
    run_div("5_7",   32'sd5,  32'sd7,  32'sd0,  32'sd5, 0);
    run_div("100_0", 32'sd100, 32'sd0, 32'hFFFF_FFFF, 32'sd100, 0);
    run_div("min_m1", 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 0);
    run_div("min_1",  32'h8000_0000, 32'd1, 32'h8000_0000, 32'd0, 0);
    run_div("max_min", 32'h7FFF_FFFF, 32'h8000_0000, 32'd0, 32'h7FFF_FFFF, 0);
    run_div("glitch", 32'sd45, 32'sd7, 32'sd6, 32'sd3, 5);

    // Reset during CALC must clear outputs without a clock edge.
    @(negedge CLK);
    Num = 32'sd9; Den = 32'sd4; Start = 1'b1;
    @(posedge CLK); #1;
    Start = 1'b0;
    repeat (10) @(posedge CLK);
    #3;
    RSTn = 1'b0;
    #1;
    chk("arst_coc", Coc, 32'd0);
    chk("arst_res", Res, 32'd0);
    chk("arst_done", 32'(Done), 32'd0);
    @(negedge CLK); RSTn = 1'b1;
    dcount = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge CLK); #1;
      if (Done) dcount++;
    end
    chk("arst_no_done", 32'(dcount), 32'd0);
    run_div("after_rst", -32'sd100, 32'sd7, -32'sd14, -32'sd2, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/divisor_algoritmico.md
Name: divisor_algoritmico

Overview:
Sequential signed integer divider using a shift-and-subtract (restoring) algorithm, one quotient bit per clock.
A Start pulse launches a division of Num by Den. After a fixed latency the block presents the quotient Coc and the remainder Res, and pulses Done.
It is a standalone arithmetic block used by control logic that waits on Done.

Parameters:
- tamanyo, 32, operand/result width in bits (two's complement); must be ≥ 2.

Ports:
- CLK  in  1  system clock; all state updates on the rising edge.
- RSTn  in  1  asynchronous active-low reset.
- Start  in  1  launch request; sampled on the rising edge while idle.
- Num  in  tamanyo  signed numerator (dividend).
- Den  in  tamanyo  signed denominator (divisor).
- Coc  out  tamanyo  signed quotient (registered).
- Res  out  tamanyo  signed remainder (registered).
- Done  out  1  one-cycle pulse; Coc/Res are valid from this cycle onward.

Behaviour:
- Interface: one clock (CLK); reset RSTn is asynchronous and active-low.
- Reset (RSTn=0, any time, including mid-division): state goes to IDLE, Coc=0, Res=0, Done=0. All internal registers are cleared and any operation in progress is abandoned.
- States: IDLE, CALC, FIN.
- IDLE:
  - On a rising edge with Start=1, capture the following and go to CALC:
    - |Num| and |Den| as tamanyo-bit unsigned magnitudes;
    - sign_q = Num[msb] XOR Den[msb];
    - sign_r = Num[msb];
    - step counter = tamanyo.
  - Num/Den may change freely after this capture edge.
- CALC, one step per edge:
  - Shift the {partial remainder, dividend} register left by 1.
  - Trial-subtract |Den| from the partial remainder, which is tamanyo+1 bits wide.
  - If the result is non-negative, keep it and set the quotient LSB to 1; otherwise restore and set the LSB to 0.
  - Decrement the counter. After tamanyo steps go to FIN.
- FIN, one edge:
  - Coc = sign_q ? −q : q.
  - Res = sign_r ? −r : r.
  - Done=1 for this one cycle; next edge returns to IDLE with Done=0.
- Latency: Start sampled at edge E0 → Coc/Res/Done update at edge E0+tamanyo+1. Done is high during the cycle between E0+tamanyo+1 and E0+tamanyo+2.
- Truncating semantics, matching C: the quotient rounds toward zero, the remainder takes the numerator's sign, and Num = Coc*Den + Res.
- Coc and Res hold their last values until the next FIN or reset. They are not cleared by Start.
- Start while in CALC or FIN is ignored; there is no queuing. Start held high continuously causes back-to-back divisions, each starting in the cycle after returning to IDLE.
- Division by zero (Den=0 captured): normal latency and Done pulse are kept, with forced results Coc = all ones (−1) and Res = Num.
- Overflow: Num = −2^(tamanyo−1), Den = −1 gives Coc = −2^(tamanyo−1), which wraps, and Res = 0. The magnitude of the most-negative value is handled as unsigned 2^(tamanyo−1).
- All arithmetic is at tamanyo bits, except the partial remainder, which is tamanyo+1 bits.

Test Plan:
- Reset, then Num=−2, Den=2, Start pulsed for 1 cycle → Done pulses exactly 33 edges after the Start edge (tamanyo=32), with Coc=−1, Res=0.
- After the first result, wait 2 cycles, then Num=2, Den=2, Start → Coc=1, Res=0, Done pulses once; Coc/Res stay stable afterwards.
- Sign/remainder matrix: 7/2 → 3,1; −7/2 → −3,−1; 7/−2 → −3,1; −7/−2 → 3,−1; 0/5 → 0,0; 5/7 → 0,5.
- Edge values:
  - 100/0 → Coc=−1, Res=100.
  - −2^31/−1 → Coc=−2^31, Res=0.
  - −2^31/1 → −2^31, 0.
  - (2^31−1)/(−2^31) → 0, 2^31−1.
- Start pulsed again mid-CALC → ignored; the original result and Done timing are unchanged. Change Num/Den after capture → the result is unaffected.
- RSTn asserted mid-CALC → Coc=0, Res=0, Done=0 immediately without waiting for a clock edge; no Done pulse follows. A new Start after release completes correctly.
